// File: rtl/quadrature_decoder_pkg.sv
// Shared definitions for the quadrature decoder: Gray state encodings,
// direction constants, step classification and the default debounce length.
package quadrature_decoder_pkg;

  localparam logic [1:0]  QS_00 = 2'b00;
  localparam logic [1:0]  QS_01 = 2'b01;
  localparam logic [1:0]  QS_11 = 2'b11;
  localparam logic [1:0]  QS_10 = 2'b10;

  localparam logic        DIR_CW  = 1'b1;
  localparam logic        DIR_CCW = 1'b0;

  localparam logic [16:0] DEBOUNCE_CYCLES_DEF = 17'd50_000;

  typedef enum logic [1:0] {
    STEP_NONE    = 2'd0,
    STEP_CW      = 2'd1,
    STEP_CCW     = 2'd2,
    STEP_ILLEGAL = 2'd3
  } step_e;

  // Clockwise walks 00->10->11->01->00; the reverse walk is counter-clockwise.
  function automatic step_e classify_step(input logic [1:0] prev, input logic [1:0] cur);
    step_e res;
    case ({prev, cur})
      {QS_00, QS_10}, {QS_10, QS_11}, {QS_11, QS_01}, {QS_01, QS_00}: res = STEP_CW;
      {QS_00, QS_01}, {QS_01, QS_11}, {QS_11, QS_10}, {QS_10, QS_00}: res = STEP_CCW;
      default: begin
        if ((prev ^ cur) == 2'b11) begin
          res = STEP_ILLEGAL;
        end else begin
          res = STEP_NONE;
        end
      end
    endcase
    return res;
  endfunction

endpackage

// File: rtl/quadrature_decoder_if.sv
// Encoder inputs, clear and position/status outputs of the quadrature decoder.
interface quadrature_decoder_if;
  logic       ENC_A;
  logic       ENC_B;
  logic       CLR;
  logic [3:0] POSICION;
  logic       DIR;
  logic       PASO;
  logic       ERROR;

  modport master (
    output ENC_A, ENC_B, CLR,
    input  POSICION, DIR, PASO, ERROR
  );

  modport slave (
    input  ENC_A, ENC_B, CLR,
    output POSICION, DIR, PASO, ERROR
  );
endinterface

// File: rtl/quadrature_decoder_debounce_filter.sv
// Two-flop synchronizer followed by a stable-level debounce counter for one
// raw encoder channel.
module debounce_filter
  import quadrature_decoder_pkg::*;
#(
  parameter logic [16:0] DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic raw,
  output logic level
);

  logic        sync1_r;
  logic        sync2_r;
  logic        filt_r;
  logic [16:0] cnt_r;

  // Metastability guard for the asynchronous encoder input.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= raw;
      sync2_r <= sync1_r;
    end
  end

  // Any return to the filtered level restarts the count from zero.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_r  <= 17'd0;
      filt_r <= 1'b0;
    end else if (sync2_r == filt_r) begin
      cnt_r  <= 17'd0;
    end else if (cnt_r == (DEBOUNCE_CYCLES - 17'd1)) begin
      cnt_r  <= 17'd0;
      filt_r <= sync2_r;
    end else begin
      cnt_r  <= cnt_r + 17'd1;
    end
  end

  assign level = filt_r;

endmodule

// File: rtl/quadrature_decoder.sv
// x4 quadrature decoder: debounced channels feed a Gray-state step detector
// driving a wrapping position counter with direction, step pulse and error flag.
module quadrature_decoder
  import quadrature_decoder_pkg::*;
#(
  parameter logic [16:0] DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter logic [3:0]  MAX_COUNT       = 4'd15
) (
  input  logic               CLK,
  input  logic               RST_N,
  quadrature_decoder_if.slave bus
);

  logic       a_f_s;
  logic       b_f_s;
  logic [1:0] cur_s;
  logic [1:0] prev_r;
  step_e      step_s;

  logic [3:0] pos_r;
  logic       dir_r;
  logic       paso_r;
  logic       err_r;
  logic [3:0] pos_nxt_s;
  logic       dir_nxt_s;
  logic       paso_nxt_s;
  logic       err_nxt_s;

  debounce_filter #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_filt_a (
    .CLK   (CLK),
    .RST_N (RST_N),
    .raw   (bus.ENC_A),
    .level (a_f_s)
  );

  debounce_filter #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_filt_b (
    .CLK   (CLK),
    .RST_N (RST_N),
    .raw   (bus.ENC_B),
    .level (b_f_s)
  );

  assign cur_s = {a_f_s, b_f_s};

  // Step decode and position update; CLR wins over a coincident step.
  always_comb begin
    step_s     = classify_step(prev_r, cur_s);
    pos_nxt_s  = pos_r;
    dir_nxt_s  = dir_r;
    paso_nxt_s = 1'b0;
    err_nxt_s  = err_r;
    if (bus.CLR) begin
      pos_nxt_s = 4'd0;
      err_nxt_s = 1'b0;
    end else begin
      case (step_s)
        STEP_CW: begin
          pos_nxt_s  = (pos_r >= MAX_COUNT) ? 4'd0 : pos_r + 4'd1;
          dir_nxt_s  = DIR_CW;
          paso_nxt_s = 1'b1;
        end
        STEP_CCW: begin
          pos_nxt_s  = ((pos_r == 4'd0) || (pos_r > MAX_COUNT)) ? MAX_COUNT : pos_r - 4'd1;
          dir_nxt_s  = DIR_CCW;
          paso_nxt_s = 1'b1;
        end
        STEP_ILLEGAL: begin
          err_nxt_s = 1'b1;
        end
        default: begin
          paso_nxt_s = 1'b0;
        end
      endcase
    end
  end

  // Output and previous-state registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      prev_r <= QS_00;
      pos_r  <= 4'd0;
      dir_r  <= 1'b0;
      paso_r <= 1'b0;
      err_r  <= 1'b0;
    end else begin
      prev_r <= cur_s;
      pos_r  <= pos_nxt_s;
      dir_r  <= dir_nxt_s;
      paso_r <= paso_nxt_s;
      err_r  <= err_nxt_s;
    end
  end

  assign bus.POSICION = pos_r;
  assign bus.DIR      = dir_r;
  assign bus.PASO     = paso_r;
  assign bus.ERROR    = err_r;

endmodule

// File: doc/quadrature_decoder.md
QUADRATURE_DECODER -- requirements
Module: quadrature_decoder

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 17'd50_000, is the number of consecutive stable cycles needed to accept an input level (1 ms at 50 MHz).
REQ-002 Parameter MAX_COUNT, default 4'd15, is the highest position value before wrap.
REQ-003 Port CLK, input, 1 bit: 50 MHz system clock; all state changes on its rising edge.
REQ-004 Port RST_N, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port ENC_A, input, 1 bit: raw encoder channel A; asynchronous and bouncing.
REQ-006 Port ENC_B, input, 1 bit: raw encoder channel B; asynchronous and bouncing.
REQ-007 Port CLR, input, 1 bit: synchronous clear of position and error; active-high level.
REQ-008 Port POSICION, output, 4 bits: current position, 0..MAX_COUNT; feeds the 7-segment display numero input.
REQ-009 Port DIR, output, 1 bit: direction of the last accepted step; 1 = clockwise (A leads B), 0 = counter-clockwise.
REQ-010 Port PASO, output, 1 bit: one-cycle pulse on each accepted step.
REQ-011 Port ERROR, output, 1 bit: sticky flag for an illegal quadrature transition.

Function
REQ-012 Each channel shall pass through a two-flop synchronizer before any other logic.
REQ-013 Debounce: each synchronized channel shall have a filtered level and a stable counter.
  - While synchronized level equals filtered level, the counter is held at 0.
  - Otherwise the counter increments each cycle.
  - The filtered level takes the new value in the cycle the counter reaches DEBOUNCE_CYCLES-1; the counter then returns to 0.
REQ-014 Debounce restart: any return of the synchronized level to the filtered value before acceptance shall reset the counter to 0.
REQ-015 Decoder state: the state shall be {A_f,B_f}, Gray sequence 00->01->11->10->00 = counter-clockwise and 00->10->11->01->00 = clockwise. The previous state is registered every cycle.
REQ-016 Valid step: on a single-bit change of state, POSICION shall update one cycle after the filtered change (x4 decoding, one count per edge).
  - Clockwise: +1, with MAX_COUNT wrapping to 0.
  - Counter-clockwise: -1, with 0 wrapping to MAX_COUNT.
  - PASO is high for exactly that cycle.
  - DIR takes the step direction.
REQ-017 Illegal change: when both filtered bits change in the same cycle, ERROR shall be set and POSICION, DIR and PASO left unchanged. The previous state is still updated.
REQ-018 Total latency from a raw edge to the POSICION update shall be 2 + DEBOUNCE_CYCLES + 1 cycles, ±1 for synchronizer sampling phase.
REQ-019 CLR high: POSICION shall become 0, ERROR 0 and PASO 0 on the next edge. CLR has priority over a simultaneous step, and that step is discarded.
REQ-020 With no transition, all outputs shall hold their values; PASO shall be 0.
REQ-021 POSICION shall never exceed MAX_COUNT.

Reset
REQ-022 RST_N low shall immediately force the following to 0: POSICION, DIR, PASO, ERROR, both debounce counters, and all synchronizer flops.
REQ-023 On reset release, the filtered and previous-state registers shall be 0. A channel held high through reset is then accepted as a normal debounced edge after DEBOUNCE_CYCLES.
REQ-024 Reset asserted mid-debounce or mid-step shall discard the pending event with no PASO pulse.

Structure
REQ-025 A shared package shall hold the quadrature state encodings (2'b00, 2'b01, 2'b11, 2'b10), the direction constants, and the default DEBOUNCE_CYCLES.
REQ-026 Synchronizer plus debounce shall be one sub-module, debounce_filter, instantiated once per channel; the decoder and position counter stay in the top level.

Verification (bench uses DEBOUNCE_CYCLES=4)
REQ-027 Four clean clockwise edges (AB 00->10->11->01->00), each stable 10 cycles, from reset -> POSICION 1,2,3,4; four PASO pulses; DIR=1; ERROR=0.
REQ-028 From POSICION=0, one counter-clockwise edge (00->01) -> POSICION=15, DIR=0. From POSICION=15, one clockwise edge -> POSICION=0.
REQ-029 Toggle ENC_A every 2 cycles for 20 cycles, then return to its original level -> no PASO and POSICION unchanged. Then hold the new level 4+ cycles -> exactly one step.
REQ-030 Drive A and B 00->11 in the same cycle, held 10 cycles -> ERROR=1, no PASO, POSICION unchanged. Assert CLR for one cycle -> ERROR=0, POSICION=0.
REQ-031 Assert RST_N low 2 cycles after a raw edge, then release -> all outputs 0 and no PASO. A further clockwise edge gives POSICION=1 after the REQ-018 latency.
